// File: rtl/gcd_lcm_sched.sv
// gcd_lcm_sched: two-requester round-robin front end sharing one
// subtract/swap GCD engine and one restoring divider (LCM = (A/GCD)*B).
// Ports: clock, reset (async active-low), req_valid/req_ready/req_a/req_b
// (two packed requesters), rsp_valid/rsp_ready/rsp_id/rsp_gcd/rsp_lcm/
// rsp_err (single result channel), busy (any state but IDLE).
module gcd_lcm_sched #(
    parameter int WIDTH = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_gcd,
    output logic [2*WIDTH-1:0]   rsp_lcm,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GCD  = 2'd1,
        DIV  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state;
    logic               prio;
    logic [WIDTH-1:0]   a, b;
    logic [WIDTH-1:0]   a_orig, b_orig;
    logic               zop;
    logic [WIDTH-1:0]   rem, quot;
    logic [CW-1:0]      cnt;

    logic [1:0]         gnt;
    logic               gid;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [WIDTH:0]     shifted, diff;
    logic               qbit;
    logic [WIDTH-1:0]   q_next;
    logic [2*WIDTH-1:0] prod;

    // Priority requester first, the other one only if prio is idle.
    always_comb begin
        gnt = 2'b00;
        if (state == IDLE) begin
            if (req_valid[prio])
                gnt[prio] = 1'b1;
            else if (req_valid[~prio])
                gnt[~prio] = 1'b1;
        end
    end

    assign req_ready = gnt;
    assign gid       = gnt[1];
    assign sel_a     = gid ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b     = gid ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    // One restoring-division step: shift in the next dividend bit
    // (quot doubles as the dividend shift register) and try subtracting g.
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        diff    = shifted - {1'b0, rsp_gcd};
        qbit    = (shifted >= {1'b0, rsp_gcd});
        q_next  = {quot[WIDTH-2:0], qbit};
        prod    = {{WIDTH{1'b0}}, q_next} * {{WIDTH{1'b0}}, b_orig};
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            prio    <= 1'b0;
            a       <= '0;
            b       <= '0;
            a_orig  <= '0;
            b_orig  <= '0;
            zop     <= 1'b0;
            rem     <= '0;
            quot    <= '0;
            cnt     <= '0;
            rsp_id  <= 1'b0;
            rsp_gcd <= '0;
            rsp_lcm <= '0;
            rsp_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        a      <= sel_a;
                        b      <= sel_b;
                        a_orig <= sel_a;
                        b_orig <= sel_b;
                        zop    <= (sel_a == '0) || (sel_b == '0);
                        rsp_id <= gid;
                        prio   <= ~gid;
                        state  <= GCD;
                    end
                end
                GCD: begin
                    if (b == '0) begin
                        rsp_gcd <= a;
                        if (zop) begin
                            // Zero operand: skip the divider, g may be 0.
                            rsp_lcm <= '0;
                            rsp_err <= (a == '0);
                            state   <= RESP;
                        end else begin
                            rem     <= '0;
                            quot    <= a_orig;
                            cnt     <= '0;
                            rsp_err <= 1'b0;
                            state   <= DIV;
                        end
                    end else if (a >= b) begin
                        a <= a - b;
                    end else begin
                        a <= b;
                        b <= a;
                    end
                end
                DIV: begin
                    rem  <= qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quot <= q_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        rsp_lcm <= prod;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_sched.sv
// tb_gcd_lcm_sched: directed self-checking bench for gcd_lcm_sched.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_gcd_lcm_sched;

    localparam int W = 11;

    logic               clock;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*W-1:0]     req_a;
    logic [2*W-1:0]     req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [W-1:0]       rsp_gcd;
    logic [2*W-1:0]     rsp_lcm;
    logic               rsp_err;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    gcd_lcm_sched #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gcd   (rsp_gcd),
        .rsp_lcm   (rsp_lcm),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands, wait (bounded) for the grant, pass the accept edge.
    task automatic send(input int id, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        int n;
        req_valid[id]      = 1'b1;
        req_a[id*W +: W]   = a;
        req_b[id*W +: W]   = b;
        #1;
        n = 0;
        while (!req_ready[id] && n < 5000) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("grant_timeout", 64'(n >= 5000), 64'd0);
        @(posedge clock);
        #1;
        req_valid[id] = 1'b0;
    endtask

    // Edges after the accept edge until rsp_valid is seen; also notes
    // whether req_ready was ever raised while waiting.
    task automatic wait_rsp(output int lat, output logic rdy_seen);
        lat      = 0;
        rdy_seen = 1'b0;
        @(negedge clock);
        while (!rsp_valid && lat < 5000) begin
            if (req_ready != 2'b00) rdy_seen = 1'b1;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int   lat;
        logic rs;
        logic bad;
        logic [W-1:0]   g0;
        logic [2*W-1:0] l0;

        reset     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_gcd",       64'(rsp_gcd),   64'd0);
        chk("rst_lcm",       64'(rsp_lcm),   64'd0);
        chk("rst_err",       64'(rsp_err),   64'd0);
        chk("rst_id",        64'(rsp_id),    64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Both requesters valid at once: req0 (prio 0) first.
        req_valid = 2'b11;
        req_a     = {11'd7, 11'd21};
        req_b     = {11'd5, 11'd6};
        #1;
        chk("both_ready_r0", 64'(req_ready), 64'd1);
        send(0, 11'd21, 11'd6);
        wait_rsp(lat, rs);
        chk("t2_id0",  64'(rsp_id),  64'd0);
        chk("t2_gcd0", 64'(rsp_gcd), 64'd3);
        chk("t2_lcm0", 64'(rsp_lcm), 64'd42);
        consume();
        #1;
        chk("t2_ready_r1", 64'(req_ready), 64'd2);
        send(1, 11'd7, 11'd5);
        wait_rsp(lat, rs);
        chk("t2_id1",  64'(rsp_id),  64'd1);
        chk("t2_gcd1", 64'(rsp_gcd), 64'd1);
        chk("t2_lcm1", 64'(rsp_lcm), 64'd35);
        consume();

        // 12,8: 5 steps + terminate + 11 divide edges.
        send(0, 11'd12, 11'd8);
        wait_rsp(lat, rs);
        chk("t1_lat", 64'(lat),     64'd17);
        chk("t1_id",  64'(rsp_id),  64'd0);
        chk("t1_gcd", 64'(rsp_gcd), 64'd4);
        chk("t1_lcm", 64'(rsp_lcm), 64'd24);
        chk("t1_err", 64'(rsp_err), 64'd0);
        consume();

        // 0,5: one swap then the terminating step, no divide.
        send(1, 11'd0, 11'd5);
        wait_rsp(lat, rs);
        chk("t3a_lat", 64'(lat),     64'd2);
        chk("t3a_gcd", 64'(rsp_gcd), 64'd5);
        chk("t3a_lcm", 64'(rsp_lcm), 64'd0);
        chk("t3a_err", 64'(rsp_err), 64'd0);
        consume();
        send(0, 11'd0, 11'd0);
        wait_rsp(lat, rs);
        chk("t3b_lat", 64'(lat),     64'd1);
        chk("t3b_gcd", 64'(rsp_gcd), 64'd0);
        chk("t3b_lcm", 64'(rsp_lcm), 64'd0);
        chk("t3b_err", 64'(rsp_err), 64'd1);
        consume();

        // 2047,2046: S = 1 + 1 + 2046 + 1 = 2049; req1 pending meanwhile.
        send(0, 11'd2047, 11'd2046);
        req_valid[1]   = 1'b1;
        req_a[2*W-1:W] = 11'd6;
        req_b[2*W-1:W] = 11'd4;
        wait_rsp(lat, rs);
        chk("t4_lat",      64'(lat),     64'd2061);
        chk("t4_gcd",      64'(rsp_gcd), 64'd1);
        chk("t4_lcm",      64'(rsp_lcm), 64'd4188162);
        chk("t4_no_ready", 64'(rs),      64'd0);

        // Back-pressure: result held, nothing accepted.
        g0  = rsp_gcd;
        l0  = rsp_lcm;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (!rsp_valid || rsp_gcd !== g0 || rsp_lcm !== l0 ||
                rsp_id !== 1'b0 || req_ready !== 2'b00)
                bad = 1'b1;
        end
        chk("t5_hold_stable", 64'(bad), 64'd0);
        consume();
        #1;
        chk("t5_next_grant", 64'(req_ready), 64'd2);
        send(1, 11'd6, 11'd4);
        wait_rsp(lat, rs);
        chk("t5_id",  64'(rsp_id),  64'd1);
        chk("t5_gcd", 64'(rsp_gcd), 64'd2);
        chk("t5_lcm", 64'(rsp_lcm), 64'd12);
        consume();

        // Reset in the middle of a long GCD run.
        send(0, 11'd100, 11'd3);
        repeat (5) @(negedge clock);
        chk("t6_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("t6_busy",  64'(busy),      64'd0);
        chk("t6_valid", 64'(rsp_valid), 64'd0);
        chk("t6_gcd",   64'(rsp_gcd),   64'd0);
        chk("t6_lcm",   64'(rsp_lcm),   64'd0);
        @(negedge clock);
        reset = 1'b1;
        bad   = 1'b0;
        repeat (200) begin
            @(negedge clock);
            if (rsp_valid || busy) bad = 1'b1;
        end
        chk("t6_no_stale", 64'(bad), 64'd0);
        req_valid = 2'b11;
        req_a     = {11'd4, 11'd9};
        req_b     = {11'd2, 11'd6};
        #1;
        chk("t6_prio0", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
